led_serial_rx: RTL and testbench



---
 rtl/led_serial_rx.sv | 107 ++++++++++
 tb/tb_led_serial_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_serial_rx.sv
// Serial-to-parallel receiver for the LED display data chain.
// Synchronises sclk/sdi/frame into clk and assembles MSB-first words.
module led_serial_rx #(
  parameter int                width      = 24,
  parameter logic [width-1:0]  init_value = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             sdi,
  input  logic             frame,
  output logic [width-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic [7:0]       word_cnt,
  output logic             busy
);

  localparam int                CNT_W    = (width > 2) ? $clog2(width) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(width - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [width-1:0]   shift;

  // sync stages: _p0 is the first flop, _p1 the usable synchronised copy
  logic sclk_p0, sclk_p1, sclk_p2;
  logic sdi_p0, sdi_p1;
  logic frame_p0, frame_p1;

  logic             sclk_rise;
  logic [width-1:0] next_word;

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign next_word = {shift[width-2:0], sdi_p1};

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_p0    <= 1'b0;
      sclk_p1    <= 1'b0;
      sclk_p2    <= 1'b0;
      sdi_p0     <= 1'b0;
      sdi_p1     <= 1'b0;
      frame_p0   <= 1'b0;
      frame_p1   <= 1'b0;
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      data_out   <= init_value;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      word_cnt   <= 8'd0;
      busy       <= 1'b0;
    end else begin
      sclk_p0    <= sclk;
      sclk_p1    <= sclk_p0;
      sclk_p2    <= sclk_p1;
      sdi_p0     <= sdi;
      sdi_p1     <= sdi_p0;
      frame_p0   <= frame;
      frame_p1   <= frame_p0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          // a bit arriving together with the frame start is deliberately dropped
          if (frame_p1) begin
            state    <= RECV;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            shift    <= '0;
            word_cnt <= 8'd0;
          end
        end

        RECV: begin
          // frame end takes priority over a coincident sclk edge
          if (!frame_p1) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= (bit_cnt != '0);
          end else if (sclk_rise) begin
            shift <= next_word;
            if (bit_cnt == LAST_BIT) begin
              data_out   <= next_word;
              data_valid <= 1'b1;
              bit_cnt    <= '0;
              if (word_cnt != 8'hFF)
                word_cnt <= word_cnt + 8'd1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_serial_rx.sv
// Randomised scoreboard bench for led_serial_rx: a word-level model queues
// expected valid/error events, a monitor pops and compares them.
module tb_led_serial_rx;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          sdi = 1'b0;
  logic          frame = 1'b0;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          frame_err;
  logic [7:0]    word_cnt;
  logic          busy;

  led_serial_rx #(.width(W), .init_value('0)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdi(sdi), .frame(frame),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
    .word_cnt(word_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    bit           is_err;
    logic [W-1:0] data;
    int           cnt;
    int           e0;
  } ev_t;

  ev_t q[$];

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  // word-level reference state
  logic [W-1:0] acc;
  int           nbits;
  int           wcnt;
  logic [W-1:0] last_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid === 1'b1 && frame_err === 1'b1)
        chk("valid_and_err_together", 1, 0);
      if (data_valid === 1'b1) begin
        vcount++;
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          ev_t e;
          e = q.pop_front();
          chk("event_kind_valid", 32'(e.is_err), 0);
          chk("data_out", 32'(data_out), 32'(e.data));
          chk("word_cnt_at_valid", 32'(word_cnt), 32'(e.cnt));
          chk("valid_latency", 32'(cyc), 32'(e.e0 + 2));
        end
      end else if (frame_err === 1'b1) begin
        if (q.size() == 0) chk("spurious_frame_err", 1, 0);
        else begin
          ev_t e;
          e = q.pop_front();
          chk("event_kind_err", 32'(e.is_err), 1);
          chk("data_out_kept_on_err", 32'(data_out), 32'(e.data));
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    sdi = b;
    tick(2);
    acc = {acc[W-2:0], b};
    nbits++;
    if (nbits == W) begin
      ev_t e;
      wcnt = (wcnt < 255) ? wcnt + 1 : 255;
      e.is_err = 1'b0; e.data = acc; e.cnt = wcnt; e.e0 = cyc + 1;
      q.push_back(e);
      last_word = acc;
      nbits = 0;
    end
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
    tick(2);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic frame_start();
    frame = 1'b1;
    nbits = 0; acc = '0; wcnt = 0;
    tick(4);
  endtask

  task automatic frame_end();
    if (nbits != 0) begin
      ev_t e;
      e.is_err = 1'b1; e.data = last_word; e.cnt = wcnt; e.e0 = 0;
      q.push_back(e);
    end
    nbits = 0;
    frame = 1'b0;
    tick(3);
    chk("busy_low_after_frame", 32'(busy), 0);
    tick(3);
    chk("word_cnt_after_frame", 32'(word_cnt), 32'(wcnt));
    chk("queue_drained", 32'(q.size()), 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1; frame = 1'b0; sclk = 1'b0; sdi = 1'b0;
    tick(2);
    rst = 1'b0;
    nbits = 0; acc = '0; wcnt = 0; last_word = '0;
    q.delete();
    tick(1);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    tick(2);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] rw;
    int           nw, np, v0;
    nbits = 0; acc = '0; wcnt = 0; last_word = '0;

    apply_reset();

    // single word
    v0 = vcount;
    frame_start();
    send_word(24'hA5C3F0);
    frame_end();
    chk("one_valid", 32'(vcount - v0), 1);

    // two words
    v0 = vcount;
    frame_start();
    send_word(24'h123456);
    send_word(24'hFEDCBA);
    frame_end();
    chk("two_valids", 32'(vcount - v0), 2);

    // partial word after reset: data_out stays at init
    apply_reset();
    v0 = vcount;
    frame_start();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    frame_end();
    chk("partial_no_valid", 32'(vcount - v0), 0);
    chk("partial_data_kept", 32'(data_out), 0);

    // reset mid-word, then a clean word
    frame_start();
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    apply_reset();
    frame_start();
    send_word(24'h000001);
    frame_end();
    chk("after_reset_word", 32'(data_out), 32'h000001);

    // sclk activity with no frame
    for (int i = 0; i < 4; i++) begin
      sdi = i[0];
      sclk = 1'b1; tick(3);
      chk("idle_busy", 32'(busy), 0);
      sclk = 1'b0; tick(3);
    end
    chk("idle_word_cnt", 32'(word_cnt), 1);
    chk("idle_data_out", 32'(data_out), 32'h000001);

    // randomised frames
    for (int f = 0; f < 4; f++) begin
      nw = $urandom_range(1, 3);
      np = $urandom_range(0, W - 1);
      frame_start();
      for (int k = 0; k < nw; k++) begin
        rw = W'($urandom);
        send_word(rw);
      end
      for (int k = 0; k < np; k++) send_bit(1'($urandom));
      frame_end();
      tick($urandom_range(1, 5));
    end

    // saturation
    v0 = vcount;
    frame_start();
    for (int k = 0; k < 256; k++) send_word('0);
    frame_end();
    chk("sat_valid_count", 32'(vcount - v0), 256);
    chk("sat_word_cnt", 32'(word_cnt), 255);

    tick(4);
    chk("final_queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
